// File: rtl/ram_reader_pkg.sv
// Shared types and sizing for the RAM stream reader: FSM states and return-buffer depth.
package ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry return buffer: push lands at the clock edge, head is visible the next cycle.
// Same-cycle push and pop leave the count unchanged; the producer must never push into a full buffer.
module skid_fifo2
  import ram_reader_pkg::*;
#(
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [data_width-1:0] push_dat,
  input  logic                  pop,
  output logic [FIFO_CNT_W-1:0] count,
  output logic [data_width-1:0] head
);

  logic [data_width-1:0] mem [FIFO_DEPTH];
  logic                  rd_ptr;
  logic                  wr_ptr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // The issue throttle upstream guarantees these never fire.
  assert property (@(posedge clk) disable iff (!rst)
    !(push && !pop && (count == FIFO_CNT_W'(FIFO_DEPTH))));
  assert property (@(posedge clk) disable iff (!rst)
    !(pop && (count == '0)));

endmodule

// File: rtl/ram_stream_reader.sv
// Reads length bytes from the synchronous RAM starting at base_addr and streams them in order; first byte valid 3 cycles after start, 1 byte/cycle.
// Stream stalls are absorbed by a 2-entry buffer; reads are throttled so it never overflows. Optional chksum port: RAM_STREAM_READER_CHKSUM_EN.
module ram_stream_reader
  import ram_reader_pkg::*;
#(
  parameter int addr_width = 12,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width-1:0] base_addr,
  input  logic [addr_width:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] r_addr,
  output logic                  r_en,
  input  logic [data_width-1:0] r_data,
  output logic [data_width-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef RAM_STREAM_READER_CHKSUM_EN
  ,
  output logic [data_width-1:0] chksum
`endif
);

  localparam logic [FIFO_CNT_W:0] OCC_LIMIT = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

  state_t                  state;
  state_t                  state_nxt;
  logic [addr_width-1:0]   base_q;
  logic [addr_width:0]     len_q;
  logic [addr_width:0]     issue_cnt;
  logic [addr_width:0]     xfer_cnt;
  logic                    inflight;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic [FIFO_CNT_W:0]     occupancy;
  logic                    pop;
  logic                    accept;
  logic                    last_issue;
  logic                    last_xfer;

  assign pop    = m_valid & m_ready;
  assign accept = (state == IDLE) && start;

  // Buffered plus in-flight bytes after this cycle's pop; a read may issue while that leaves room.
  assign occupancy = {1'b0, fifo_count}
                   + {{FIFO_CNT_W{1'b0}}, inflight}
                   - {{FIFO_CNT_W{1'b0}}, pop};

  assign r_en       = (state == RUN) && (occupancy < OCC_LIMIT);
  assign r_addr     = base_q + issue_cnt[addr_width-1:0];
  assign last_issue = r_en && ((issue_cnt + 1'b1) == len_q);
  assign last_xfer  = pop && ((xfer_cnt + 1'b1) == len_q);
  assign m_valid    = (fifo_count != '0);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = (length == '0) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_issue) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (last_xfer) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      xfer_cnt  <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= r_en;
      if (accept) begin
        base_q    <= base_addr;
        len_q     <= length;
        issue_cnt <= '0;
        xfer_cnt  <= '0;
      end else begin
        if (r_en) issue_cnt <= issue_cnt + 1'b1;
        if (pop)  xfer_cnt  <= xfer_cnt + 1'b1;
      end
    end
  end

  // RAM dout for a read issued last cycle is captured here; a reset drops it via inflight.
  skid_fifo2 #(
    .data_width(data_width)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_dat (r_data),
    .pop      (pop),
    .count    (fifo_count),
    .head     (m_data)
  );

`ifdef RAM_STREAM_READER_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst || accept) chksum <= '0;
    else if (pop)       chksum <= chksum + m_data;
  end
`endif

endmodule
